uart_rx: RTL and testbench

Oversampling UART receiver: the consumer of the 16×-baud oversampling tick. It synchronises the asynchronous serial line, detects and validates start bits, samples each bit at mid-period, and presents received words on a valid/ready output. Framing errors and overruns are reported as one-cycle pulses. It sits between the pad-side RX pin and the UART peripheral's register/FIFO logic, driven by the tick generator on the same clock.

---
 rtl/uart_rx.sv | 172 +++++++++++++++++
 tb/tb_uart_rx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver (LSB first, no parity, one stop bit).
// Synchronises the line, validates start bits and presents words on a valid/ready output.
module uart_rx #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);
    localparam int unsigned NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [NW-1:0] LAST_BIT = NW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [3:0]             r_s;
    logic [3:0]             w_s_next;
    logic [NW-1:0]          r_n;
    logic [NW-1:0]          w_n_next;
    logic [DATA_BITS-1:0]   r_sh;
    logic [DATA_BITS-1:0]   w_sh_next;
    logic                   w_rx_s;
    logic                   w_deliver;
    logic                   w_frame_err;

    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   r_busy;

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // Synchroniser resets to the idle-high line level.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
            r_s     <= '0;
            r_n     <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_sh    <= w_sh_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_sh_next    = r_sh;
        w_deliver    = 1'b0;
        w_frame_err  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_tick && !w_rx_s) begin
                    w_state_next = StStart;
                    w_s_next     = '0;
                end
            end
            StStart: begin
                if (i_tick) begin
                    if (r_s == 4'd7) begin
                        // Line must still be low at mid start bit, else it was a glitch.
                        w_s_next     = '0;
                        w_n_next     = '0;
                        w_state_next = w_rx_s ? StIdle : StData;
                    end else begin
                        w_s_next = r_s + 4'd1;
                    end
                end
            end
            StData: begin
                if (i_tick) begin
                    if (r_s == 4'd15) begin
                        w_sh_next = {w_rx_s, r_sh[DATA_BITS-1:1]};
                        w_s_next  = '0;
                        if (r_n == LAST_BIT) begin
                            w_state_next = StStop;
                        end else begin
                            w_n_next = r_n + 1'b1;
                        end
                    end else begin
                        w_s_next = r_s + 4'd1;
                    end
                end
            end
            StStop: begin
                if (i_tick) begin
                    if (r_s == 4'd15) begin
                        w_s_next = '0;
                        if (w_rx_s) begin
                            w_deliver    = 1'b1;
                            w_state_next = StIdle;
                        end else begin
                            w_frame_err  = 1'b1;
                            w_state_next = StWaitIdle;
                        end
                    end else begin
                        w_s_next = r_s + 4'd1;
                    end
                end
            end
            StWaitIdle: begin
                // Hold off through a break so it is not re-detected as a start bit.
                if (w_rx_s) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= 1'b0;
            r_busy      <= (w_state_next != StIdle);
            if (w_deliver) begin
                if (!r_valid || i_ready) begin
                    r_data  <= r_sh;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random bytes against a word-level model.
module tb_uart_rx;
    localparam int CPB        = 416;
    localparam int STOP_TICKS = 152;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick = 1'b0;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int tcnt = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int n_rise = 0;
    int n_wide = 0;
    int n_both = 0;
    logic prev_valid = 1'b0;
    logic prev_ferr = 1'b0;
    logic prev_ovr = 1'b0;
    logic [7:0] q_got[$];
    logic [7:0] q_exp[$];

    uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_tick     (tick),
        .i_rx       (rx),
        .o_data     (data),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_frame_err(ferr),
        .o_overrun  (ovr),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tcnt <= (tcnt == 25) ? 0 : tcnt + 1;
        tick <= (tcnt == 25);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ferr) n_ferr++;
            if (ovr) n_ovr++;
            if (ferr && ovr) n_both++;
            if ((ferr && prev_ferr) || (ovr && prev_ovr)) n_wide++;
            if (valid && !prev_valid) n_rise++;
            if (valid && ready) q_got.push_back(data);
        end
        prev_valid = valid;
        prev_ferr  = ferr;
        prev_ovr   = ovr;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(CPB);
        end
        rx = stop;
        step(CPB);
        rx = 1'b1;
    endtask

    // Returns at the negedge after busy rises, i.e. one clock after the start-detecting tick.
    task automatic wait_frame_start;
        int k = 0;
        while (busy && k < 20000) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (!busy && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20000) chk("start_timeout", busy, 1);
    endtask

    task automatic wait_ticks(input int n);
        int c = 0;
        int k = 0;
        while (c < n && k < 50000) begin
            @(negedge clk);
            k++;
            if (tick) c++;
        end
    endtask

    initial begin
        int base;
        logic [7:0] b;

        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        step(5);
        chk("reset_valid", valid, 0);
        chk("reset_data", data, 0);
        chk("reset_ferr", ferr, 0);
        chk("reset_ovr", ovr, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        step(50);

        // Basic receive with exact stop-tick latency.
        base = n_rise;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_frame_start();
                wait_ticks(STOP_TICKS);
                chk("basic_pre_valid", valid, 0);
                chk("basic_pre_busy", busy, 1);
                @(negedge clk);
                chk("basic_valid", valid, 1);
                chk("basic_data", data, 8'hA5);
                chk("basic_busy_low", busy, 0);
                @(negedge clk);
                chk("basic_consumed", valid, 0);
            end
        join
        step(20);
        chk("basic_rise_count", n_rise - base, 1);
        chk("basic_no_err", n_ferr + n_ovr, 0);

        // Glitch rejection.
        base = n_rise;
        fork
            begin
                rx = 1'b0;
                step(4 * 26);
                rx = 1'b1;
            end
            begin
                wait_frame_start();
                wait_ticks(8);
                chk("glitch_busy_hi", busy, 1);
                @(negedge clk);
                chk("glitch_busy_lo", busy, 0);
            end
        join
        step(200);
        chk("glitch_no_valid", n_rise - base, 0);
        base = q_got.size();
        send_frame(8'h3C, 1'b1);
        step(20);
        chk("glitch_next_cnt", q_got.size() - base, 1);
        chk("glitch_next_data", q_got[q_got.size() - 1], 8'h3C);

        // Framing error then break.
        base = n_ferr;
        fork
            begin
                send_frame(8'h3C, 1'b0);
                rx = 1'b0;
                step(40 * 26);
                rx = 1'b1;
            end
            begin
                wait_frame_start();
                wait_ticks(STOP_TICKS);
                @(negedge clk);
                chk("ferr_pulse", ferr, 1);
                chk("ferr_no_valid", valid, 0);
                chk("ferr_wait_busy", busy, 1);
                @(negedge clk);
                chk("ferr_pulse_end", ferr, 0);
            end
        join
        @(negedge clk);
        chk("break_busy_held", busy, 1);
        step(6);
        chk("break_busy_released", busy, 0);
        chk("ferr_count", n_ferr - base, 1);
        base = q_got.size();
        send_frame(8'h81, 1'b1);
        step(20);
        chk("after_ferr_data", q_got[q_got.size() - 1], 8'h81);
        chk("after_ferr_cnt", q_got.size() - base, 1);

        // Overrun: back-to-back frames with the consumer stalled.
        ready = 1'b0;
        base  = n_ovr;
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                wait_frame_start();
                wait_ticks(STOP_TICKS);
                @(negedge clk);
                chk("ovr_first_data", data, 8'h11);
                @(negedge clk);
                wait_frame_start();
                wait_ticks(STOP_TICKS);
                @(negedge clk);
                chk("ovr_pulse", ovr, 1);
                chk("ovr_valid_held", valid, 1);
                chk("ovr_data_kept", data, 8'h11);
                @(negedge clk);
                chk("ovr_pulse_end", ovr, 0);
            end
        join
        chk("ovr_count", n_ovr - base, 1);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        step(1);
        chk("ovr_consumed", valid, 0);
        chk("ovr_data_after", data, 8'h11);

        // Completion and acceptance on the same clock.
        send_frame(8'h11, 1'b1);
        step(5);
        chk("sim_hold_data", data, 8'h11);
        base = n_ovr;
        fork
            send_frame(8'h22, 1'b1);
            begin
                wait_frame_start();
                wait_ticks(STOP_TICKS);
                ready = 1'b1;
                @(posedge clk);
                #1;
                ready = 1'b0;
                @(negedge clk);
                chk("sim_valid", valid, 1);
                chk("sim_data", data, 8'h22);
                chk("sim_no_ovr", ovr, 0);
            end
        join
        chk("sim_ovr_count", n_ovr - base, 0);
        ready = 1'b1;
        step(3);
        chk("sim_consumed", valid, 0);

        // Asynchronous reset during bit 3.
        fork
            send_frame(8'hF0, 1'b1);
            begin
                wait_frame_start();
                step(4 * CPB + 200);
                #2;
                rst_n = 1'b0;
                #1;
                chk("rst_valid", valid, 0);
                chk("rst_data", data, 0);
                chk("rst_busy", busy, 0);
                chk("rst_ferr", ferr, 0);
                chk("rst_ovr", ovr, 0);
            end
        join
        step(5);
        base  = q_got.size();
        rst_n = 1'b1;
        step(50);
        send_frame(8'h5A, 1'b1);
        step(20);
        chk("rst_next_cnt", q_got.size() - base, 1);
        chk("rst_next_data", q_got[q_got.size() - 1], 8'h5A);

        // Random bytes with random idle gaps, compared in order against the model queue.
        base = q_got.size();
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            q_exp.push_back(b);
            send_frame(b, 1'b1);
            step($urandom_range(0, 200));
        end
        step(50);
        chk("rand_count", q_got.size() - base, q_exp.size());
        for (int i = 0; i < q_exp.size(); i++) begin
            if (base + i < q_got.size()) chk("rand_data", q_got[base + i], q_exp[i]);
        end

        chk("pulse_width", n_wide, 0);
        chk("err_and_ovr", n_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
